alink_rx_fifo: RTL

//  Packet buffer downstream of the RX collector (rxc). Accepts 5-word result

---
 rtl/alink_rx_fifo_pkg.sv | 42 ++++
 rtl/alink_rx_fifo_if.sv | 27 ++
 rtl/alink_dpram.sv | 34 +++
 rtl/alink_rx_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alink_rx_fifo_pkg.sv
// Shared constants, types and helpers for the ALINK result-packet receive buffer.
package alink_rx_fifo_pkg;

    localparam int unsigned DEPTH_LOG2   = 6;
    localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W        = DEPTH_LOG2 + 1;
    localparam int unsigned DAT_W        = 32;
    localparam int unsigned PKT_WORDS    = 5;
    localparam int unsigned CNT_W        = $clog2(PKT_WORDS + 1);
    localparam int unsigned AFULL_THRESH = 10;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [DAT_W-1:0] word_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Word order inside a result packet; W_NONCE is always the last word.
    typedef enum logic [CNT_W-1:0] {
        W_RXID  = 3'd0,
        W_TID_H = 3'd1,
        W_TID_L = 3'd2,
        W_TIME  = 3'd3,
        W_NONCE = 3'd4
    } pkt_word_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DROP,
        ST_RESYNC
    } rx_state_e;

    typedef struct packed {
        logic err_len;
        logic err_ovf;
    } rx_err_t;

    // Free storage words given a write pointer and the read pointer.
    function automatic ptr_t free_words(input ptr_t wr, input ptr_t rd);
        return PTR_W'(DEPTH) - (wr - rd);
    endfunction

endpackage

// File: rtl/alink_rx_fifo_if.sv
// Burst input, CPU read path and status of the receive buffer.
interface alink_rx_fifo_if;
    import alink_rx_fifo_pkg::*;

    logic  reg_flush;
    logic  rx_vld;
    word_t rx_dat;
    logic  rx_almost_full;
    logic  rd_en;
    word_t rd_dat;
    logic  rd_dat_vld;
    ptr_t  word_cnt;
    ptr_t  pkt_cnt;
    logic  err_len;
    logic  err_ovf;

    modport master (
        output reg_flush, rx_vld, rx_dat, rd_en,
        input  rx_almost_full, rd_dat, rd_dat_vld, word_cnt, pkt_cnt, err_len, err_ovf
    );

    modport slave (
        input  reg_flush, rx_vld, rx_dat, rd_en,
        output rx_almost_full, rd_dat, rd_dat_vld, word_cnt, pkt_cnt, err_len, err_ovf
    );

endinterface

// File: rtl/alink_dpram.sv
// 1W/1R synchronous RAM with a registered read port that holds between reads.
module alink_dpram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned WORDS = 1 << AW;

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alink_rx_fifo.sv
// Packet buffer behind the RX collector: stores only complete 5-word result
// packets, rolls back truncated or overflowing bursts, and serves CPU reads.
module alink_rx_fifo
    import alink_rx_fifo_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    alink_rx_fifo_if.slave bus
);

    rx_state_e state;
    ptr_t      wr_ptr;
    ptr_t      wr_spec;
    ptr_t      rd_ptr;
    ptr_t      word_cnt_q;
    ptr_t      pkt_cnt_q;
    cnt_t      wcnt;
    cnt_t      rcnt;
    rx_err_t   err_q;
    logic      rd_vld_q;
    logic      afull_q;

    ptr_t      used_spec;
    ptr_t      wr_spec_nxt;
    ptr_t      wr_ptr_nxt;
    ptr_t      rd_ptr_nxt;
    logic      space;
    logic      wr_en;
    logic      commit;
    logic      roll_len;
    logic      roll_ovf;
    logic      to_drop;
    logic      pop;
    logic      last_pop;

    // Per-cycle write/commit/rollback/pop decode and the resulting pointer values.
    always_comb begin
        wr_en     = 1'b0;
        to_drop   = 1'b0;
        roll_len  = 1'b0;
        roll_ovf  = 1'b0;
        used_spec = wr_spec - rd_ptr;
        space     = used_spec < PTR_W'(DEPTH);
        pop       = bus.rd_en && (wr_ptr != rd_ptr);

        unique case (state)
            ST_IDLE: begin
                if (bus.rx_vld) begin
                    wr_en   = space;
                    to_drop = !space;
                end
            end
            ST_BURST: begin
                if (bus.rx_vld) begin
                    wr_en   = space;
                    to_drop = !space;
                end else begin
                    roll_len = 1'b1;
                end
            end
            ST_DROP: begin
                roll_ovf = !bus.rx_vld;
            end
            default: begin
            end
        endcase

        commit      = wr_en && (wcnt == cnt_t'(W_NONCE));
        last_pop    = pop && (rcnt == cnt_t'(W_NONCE));
        wr_spec_nxt = (roll_len || roll_ovf) ? wr_ptr : wr_spec + PTR_W'(wr_en);
        wr_ptr_nxt  = commit ? wr_spec + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt  = rd_ptr + PTR_W'(pop);
    end

    alink_dpram #(
        .AW (DEPTH_LOG2),
        .DW (DAT_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && !bus.reg_flush),
        .waddr (wr_spec[DEPTH_LOG2-1:0]),
        .wdata (bus.rx_dat),
        .re    (pop && !bus.reg_flush),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (bus.rd_dat)
    );

    // Burst FSM, pointers, counters and status flags; flush outranks traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            wr_spec    <= '0;
            rd_ptr     <= '0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            err_q      <= '0;
            rd_vld_q   <= 1'b0;
            afull_q    <= 1'b0;
        end else if (bus.reg_flush) begin
            state      <= bus.rx_vld ? ST_RESYNC : ST_IDLE;
            wr_ptr     <= '0;
            wr_spec    <= '0;
            rd_ptr     <= '0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            err_q      <= '0;
            rd_vld_q   <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            wr_spec    <= wr_spec_nxt;
            rd_ptr     <= rd_ptr_nxt;
            word_cnt_q <= wr_ptr_nxt - rd_ptr_nxt;
            afull_q    <= free_words(wr_spec_nxt, rd_ptr_nxt) < PTR_W'(AFULL_THRESH);
            rd_vld_q   <= pop;

            if (commit || roll_len || roll_ovf) begin
                wcnt <= '0;
            end else if (wr_en) begin
                wcnt <= wcnt + CNT_W'(1);
            end

            if (pop) begin
                rcnt <= last_pop ? '0 : rcnt + CNT_W'(1);
            end

            // A commit and a last-word pop in the same cycle cancel out.
            if (commit && !last_pop) begin
                pkt_cnt_q <= pkt_cnt_q + PTR_W'(1);
            end else if (last_pop && !commit) begin
                pkt_cnt_q <= pkt_cnt_q - PTR_W'(1);
            end

            err_q.err_len <= err_q.err_len | roll_len;
            err_q.err_ovf <= err_q.err_ovf | roll_ovf;

            unique case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        state <= commit ? ST_IDLE : ST_BURST;
                    end else if (to_drop) begin
                        state <= ST_DROP;
                    end
                end
                ST_BURST: begin
                    if (commit || roll_len) begin
                        state <= ST_IDLE;
                    end else if (to_drop) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (roll_ovf) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESYNC: begin
                    if (!bus.rx_vld) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_almost_full = afull_q;
    assign bus.rd_dat_vld     = rd_vld_q;
    assign bus.word_cnt       = word_cnt_q;
    assign bus.pkt_cnt        = pkt_cnt_q;
    assign bus.err_len        = err_q.err_len;
    assign bus.err_ovf        = err_q.err_ovf;

endmodule
